// File: rtl/unibus_master_if.sv
// Unibus signal bundle between the master and the slave side of the bus.
// Data/SSYN/BBSY come in from the bus; address, control, MSYN, BBSY and data are driven out.
interface unibus_master_if;
    logic [15:0] bus_d;
    logic        bus_ssyn;
    logic        bus_bbsy;
    logic [17:0] bus_addr_out;
    logic        bus_c0_out;
    logic        bus_c1_out;
    logic        bus_msyn_out;
    logic        bus_bbsy_out;
    logic [15:0] bus_d_out;

    modport master (
        input  bus_d, bus_ssyn, bus_bbsy,
        output bus_addr_out, bus_c0_out, bus_c1_out, bus_msyn_out, bus_bbsy_out, bus_d_out
    );

    modport slave (
        output bus_d, bus_ssyn, bus_bbsy,
        input  bus_addr_out, bus_c0_out, bus_c1_out, bus_msyn_out, bus_bbsy_out, bus_d_out
    );
endinterface

// File: rtl/unibus_master.sv
// Unibus initiator running single DATI/DATO/DATOB cycles for a local requester; UNIBUS_TIMEOUT_EN adds the no-SSYN bus error.
// Latency: req to done = 1 + 1 + DESKEW + 3 + 2 + DESKEW clocks with an immediate slave.
// Backpressure: req is ignored while busy; the cycle stalls in WAIT on a busy bus and in MSYN until SSYN.
module unibus_master #(
    parameter int DESKEW  = 4,
    parameter int TIMEOUT = 500
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bus_init,
    input  logic                 req,
    input  logic                 we,
    input  logic                 byte_op,
    input  logic [17:0]          addr,
    input  logic [15:0]          wdata,
    output logic                 done,
    output logic                 err,
    output logic [15:0]          rdata,
    output logic                 busy,
    unibus_master_if.master      bus
);

    localparam int DW = (DESKEW > 1) ? $clog2(DESKEW) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SETUP,
        ST_MSYN,
        ST_RELEASE
    } state_t;

    state_t          state, state_nxt;
    logic [DW-1:0]   dcnt, dcnt_nxt;
    logic            done_nxt;
    logic            cap;
    logic [1:0]      ssyn_sync, bbsy_sync;
    logic            ssyn_s, bbsy_s;
    logic [17:0]     addr_q;
    logic [15:0]     wdata_q;
    logic            we_q, byte_q;
    logic            drive;

    assign ssyn_s = ssyn_sync[1];
    assign bbsy_s = bbsy_sync[1];

`ifdef UNIBUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt, tcnt_nxt;
    logic          err_flag, err_flag_nxt;
`endif

    always_comb begin
        state_nxt = state;
        dcnt_nxt  = dcnt;
        done_nxt  = 1'b0;
        cap       = 1'b0;
`ifdef UNIBUS_TIMEOUT_EN
        tcnt_nxt     = tcnt;
        err_flag_nxt = err_flag;
`endif
        case (state)
            ST_IDLE: begin
                if (req) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (!(bbsy_s | ssyn_s)) begin
                    state_nxt = ST_SETUP;
                    dcnt_nxt  = '0;
                end
            end
            ST_SETUP: begin
                if (dcnt == DW'(DESKEW - 1)) begin
                    state_nxt = ST_MSYN;
`ifdef UNIBUS_TIMEOUT_EN
                    tcnt_nxt  = '0;
`endif
                end else begin
                    dcnt_nxt = dcnt + 1'b1;
                end
            end
            ST_MSYN: begin
                if (ssyn_s) begin
                    state_nxt = ST_RELEASE;
                    dcnt_nxt  = '0;
                    cap       = !we_q;
`ifdef UNIBUS_TIMEOUT_EN
                    err_flag_nxt = 1'b0;
                end else if (tcnt == TW'(TIMEOUT)) begin
                    state_nxt    = ST_RELEASE;
                    dcnt_nxt     = '0;
                    err_flag_nxt = 1'b1;
                end else begin
                    tcnt_nxt = tcnt + 1'b1;
`endif
                end
            end
            ST_RELEASE: begin
                // Address hold only starts once the slave has dropped SSYN.
                if (ssyn_s) begin
                    dcnt_nxt = '0;
                end else if (dcnt == DW'(DESKEW - 1)) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    dcnt_nxt = dcnt + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (bus_init) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b0;
            cap       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            dcnt      <= '0;
            done      <= 1'b0;
            rdata     <= '0;
            ssyn_sync <= '0;
            bbsy_sync <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            byte_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            dcnt      <= dcnt_nxt;
            done      <= done_nxt;
            ssyn_sync <= {ssyn_sync[0], bus.bus_ssyn};
            bbsy_sync <= {bbsy_sync[0], bus.bus_bbsy};
            // The sync delay on SSYN doubles as deskew for the slave's data.
            if (cap) rdata <= bus.bus_d;
            if (state == ST_IDLE && req) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                we_q    <= we;
                byte_q  <= byte_op;
            end
        end
    end

`ifdef UNIBUS_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt     <= '0;
            err_flag <= 1'b0;
            err      <= 1'b0;
        end else begin
            tcnt     <= tcnt_nxt;
            err_flag <= err_flag_nxt;
            err      <= done_nxt & err_flag_nxt;
        end
    end
`else
    assign err = 1'b0;
`endif

    // Outputs decode straight from state so an async reset drops the bus at once.
    assign drive             = (state == ST_SETUP) || (state == ST_MSYN) || (state == ST_RELEASE);
    assign busy              = (state != ST_IDLE);
    assign bus.bus_bbsy_out  = drive;
    assign bus.bus_msyn_out  = (state == ST_MSYN);
    assign bus.bus_addr_out  = drive ? addr_q : 18'h0;
    assign bus.bus_c1_out    = drive & we_q;
    assign bus.bus_c0_out    = drive & we_q & byte_q;
    assign bus.bus_d_out     = !(drive & we_q) ? 16'h0 :
                               byte_q ? {wdata_q[7:0], wdata_q[7:0]} : wdata_q;

endmodule
